// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the PC fetch sequencer.
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    // Which rule produced the committed next PC.
    typedef enum logic [1:0] {
        SEL_JALR = 2'd0,
        SEL_REL  = 2'd1,
        SEL_HOLD = 2'd2,
        SEL_INC  = 2'd3
    } sel_t;

endpackage

// File: rtl/pc_fetch_sequencer_target_sel.sv
// Next-PC priority select: jalr > jal/branch > halt > sequential.
module pc_target_sel
    import pc_fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] pc_incre,
    input  logic [31:0] imm,
    input  logic [31:0] alu_result,
    input  logic        cnd,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic        halt,
    output logic [31:0] target,
    output sel_t        sel
);

    // Priority mux; a taken jump or branch overrides a simultaneous halt.
    always_comb begin
        target = pc_incre;
        sel    = SEL_INC;
        if (jump_reg) begin
            target = {alu_result[31:1], 1'b0};
            sel    = SEL_JALR;
        end else if (jump || cnd) begin
            target = pc + imm;
            sel    = SEL_REL;
        end else if (halt) begin
            target = pc;
            sel    = SEL_HOLD;
        end
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// PC owner and fetch/execute sequencer for the RV32 core.
// Optional build macro PC_MISALIGN_TRAP_EN: traps committed targets that are
// not word aligned and adds the sticky misalign_err output.
//
// state | meaning
// BOOT  | one idle cycle after reset
// FETCH | request pc from imem, wait for ready or time out
// EXEC  | instruction presented to datapath, next PC committed
// HALT  | stopped until reset
module pc_fetch_sequencer
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_incre,
    input  logic        cnd,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic        halt,
    input  logic [31:0] imm,
    input  logic [31:0] alu_result,
    output logic        halted,
    output logic        timeout_err,
    output logic [31:0] retire_count
`ifdef PC_MISALIGN_TRAP_EN
    ,
    output logic        misalign_err
`endif
);

    localparam int CNT_W = $clog2(FETCH_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FETCH_TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic [31:0]      target;
    sel_t             sel;
    logic             load_instr, cnt_clr, cnt_inc, commit, fault_tmo, halt_req;
    logic             misaligned;

    assign imem_addr = pc;
    assign pc_incre  = pc + PC_STEP;

    pc_target_sel u_target_sel (
        .pc         (pc),
        .pc_incre   (pc_incre),
        .imm        (imm),
        .alu_result (alu_result),
        .cnd        (cnd),
        .jump       (jump),
        .jump_reg   (jump_reg),
        .halt       (halt),
        .target     (target),
        .sel        (sel)
    );

`ifdef PC_MISALIGN_TRAP_EN
    assign misaligned = |target[1:0];
`else
    assign misaligned = 1'b0;
`endif

    // Next-state decode and per-state strobes.
    always_comb begin
        state_nxt   = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        load_instr  = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        commit      = 1'b0;
        fault_tmo   = 1'b0;
        halt_req    = 1'b0;
        case (state)
            BOOT: state_nxt = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    load_instr = 1'b1;
                    cnt_clr    = 1'b1;
                    state_nxt  = EXEC;
                end else if (wait_cnt == CNT_LAST) begin
                    fault_tmo = 1'b1;
                    state_nxt = HALT;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            EXEC: begin
                instr_valid = 1'b1;
                if (sel == SEL_HOLD || misaligned) begin
                    halt_req  = 1'b1;
                    state_nxt = HALT;
                end else begin
                    commit    = 1'b1;
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = HALT;
        endcase
    end

    // State, PC, instruction latch, wait counter and sticky status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= BOOT;
            pc           <= RESET_PC;
            instr        <= 32'd0;
            wait_cnt     <= '0;
            halted       <= 1'b0;
            timeout_err  <= 1'b0;
            retire_count <= 32'd0;
`ifdef PC_MISALIGN_TRAP_EN
            misalign_err <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (load_instr) instr <= imem_rdata;
            if (cnt_clr) wait_cnt <= '0;
            else if (cnt_inc) wait_cnt <= wait_cnt + 1'b1;
            if (commit) begin
                pc           <= target;
                retire_count <= retire_count + 32'd1;
            end
            if (fault_tmo) begin
                timeout_err <= 1'b1;
                halted      <= 1'b1;
            end
            if (halt_req) halted <= 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
            if (halt_req && sel != SEL_HOLD) misalign_err <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Scoreboard bench for pc_fetch_sequencer: a driver plays instruction memory
// and datapath, a spec-level model predicts fetch addresses and EXEC contents,
// and a monitor checks them as the DUT presents them.
module tb_pc_fetch_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          TMO      = 16;

    logic        clk, rst;
    logic        imem_req, imem_ready, instr_valid;
    logic [31:0] imem_addr, imem_rdata, instr, pc, pc_incre;
    logic        cnd, jump, jump_reg, halt;
    logic [31:0] imm, alu_result;
    logic        halted, timeout_err;
    logic [31:0] retire_count;
`ifdef PC_MISALIGN_TRAP_EN
    logic        misalign_err;
`endif

    pc_fetch_sequencer #(.RESET_PC(RESET_PC), .FETCH_TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .pc           (pc),
        .pc_incre     (pc_incre),
        .cnd          (cnd),
        .jump         (jump),
        .jump_reg     (jump_reg),
        .halt         (halt),
        .imm          (imm),
        .alu_result   (alu_result),
        .halted       (halted),
        .timeout_err  (timeout_err),
        .retire_count (retire_count)
`ifdef PC_MISALIGN_TRAP_EN
        ,
        .misalign_err (misalign_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
        logic [31:0] ret;
    } exec_t;

    exec_t       exp_exec[$];
    logic [31:0] exp_fetch[$];

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [31:0] m_pc, m_ret;
    logic        m_halted, m_tmo, m_mis;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares fetch addresses and EXEC contents against the queues.
    initial begin
        logic  prev_req;
        exec_t e;
        logic [31:0] a;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req = 1'b0;
            end else begin
                if (imem_req && !prev_req) begin
                    if (exp_fetch.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_fetch: got addr %h, expected no fetch", imem_addr);
                    end else begin
                        a = exp_fetch.pop_front();
                        chk("fetch_addr", imem_addr, a);
                    end
                end
                if (instr_valid) begin
                    if (exp_exec.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_exec: got pc %h, expected no EXEC", pc);
                    end else begin
                        e = exp_exec.pop_front();
                        chk("exec_pc", pc, e.pc);
                        chk("exec_instr", instr, e.word);
                        chk("exec_retire", retire_count, e.ret);
                        chk("exec_pc_incre", pc_incre, e.pc + 32'd4);
                        chk("exec_imem_req", {31'd0, imem_req}, 32'd0);
                    end
                end
                prev_req = imem_req;
            end
        end
    end

    task automatic junk();
        cnd        = 1'($urandom_range(0, 1));
        jump       = 1'($urandom_range(0, 1));
        jump_reg   = 1'($urandom_range(0, 1));
        halt       = 1'($urandom_range(0, 1));
        imm        = $urandom;
        alu_result = $urandom;
        imem_rdata = $urandom;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        imem_ready = 1'b0;
        junk();
        @(negedge clk);
        chk("rst_pc", pc, RESET_PC);
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        chk("rst_retire", retire_count, 32'd0);
`ifdef PC_MISALIGN_TRAP_EN
        chk("rst_misalign_err", {31'd0, misalign_err}, 32'd0);
`endif
        exp_fetch.delete();
        exp_exec.delete();
        m_pc = RESET_PC; m_ret = 32'd0;
        m_halted = 1'b0; m_tmo = 1'b0; m_mis = 1'b0;
        exp_fetch.push_back(RESET_PC);
        rst = 1'b0;
    endtask

    // One instruction: wait for the request, stall d cycles, return a word,
    // then drive the given control inputs during EXEC.
    task automatic run_instr(input int d, input logic jr, input logic j, input logic c,
                             input logic h, input logic [31:0] imm_v, input logic [31:0] alu_v);
        int k;
        logic [31:0] w, t;
        logic hold, trap;
        k = 0;
        while (imem_req !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (imem_req !== 1'b1) begin
            n_vec++; n_err++;
            $display("FAIL fetch_wait: imem_req=%b after %0d cycles, expected 1", imem_req, k);
            m_halted = 1'b1;
            return;
        end
        for (int i = 0; i < d && i < TMO; i++) begin
            imem_ready = 1'b0;
            junk();
            @(negedge clk);
        end
        if (d >= TMO) begin
            m_halted = 1'b1;
            m_tmo    = 1'b1;
            return;
        end
        w = $urandom;
        imem_ready = 1'b1;
        imem_rdata = w;
        exp_exec.push_back('{m_pc, w, m_ret});
        @(negedge clk);
        imem_ready = 1'($urandom_range(0, 1));
        imem_rdata = $urandom;
        jump_reg = jr; jump = j; cnd = c; halt = h;
        imm = imm_v; alu_result = alu_v;
        hold = 1'b0;
        trap = 1'b0;
        if (jr)          t = alu_v & 32'hFFFF_FFFE;
        else if (j || c) t = m_pc + imm_v;
        else if (h)      begin t = m_pc; hold = 1'b1; end
        else             t = m_pc + 32'd4;
`ifdef PC_MISALIGN_TRAP_EN
        if (!hold && t[1:0] != 2'b00) trap = 1'b1;
`endif
        if (hold) begin
            m_halted = 1'b1;
        end else if (trap) begin
            m_halted = 1'b1;
            m_mis    = 1'b1;
        end else begin
            m_pc  = t;
            m_ret = m_ret + 32'd1;
            exp_fetch.push_back(t);
        end
        @(negedge clk);
        imem_ready = 1'b0;
        junk();
    endtask

    task automatic check_halt();
        for (int i = 0; i < 3; i++) begin
            imem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("halt_halted", {31'd0, halted}, 32'd1);
            chk("halt_timeout_err", {31'd0, timeout_err}, {31'd0, m_tmo});
            chk("halt_imem_req", {31'd0, imem_req}, 32'd0);
            chk("halt_instr_valid", {31'd0, instr_valid}, 32'd0);
            chk("halt_pc", pc, m_pc);
            chk("halt_retire", retire_count, m_ret);
`ifdef PC_MISALIGN_TRAP_EN
            chk("halt_misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
`endif
        end
        imem_ready = 1'b0;
    endtask

    task automatic finish_segment();
        if (!m_halted) run_instr(0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
        check_halt();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, d;
        logic [31:0] iv;
        rst = 1'b1;
        imem_ready = 1'b0;
        junk();

        // sequential fetches 0,4,8
        do_reset();
        for (int i = 0; i < 3; i++) run_instr(0, 1'b0, 1'b0, 1'b0, 1'b0, $urandom, $urandom);
        chk("seq_retire3", retire_count, 32'd3);
        chk("seq_pc12", pc, 32'h0000_000C);

        // pc 0xC -> 0x100, backward branch to 0xF0, then jalr 0x203
        run_instr(0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_00F4, $urandom);
        run_instr(1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF0, $urandom);
        chk("branch_back_pc", pc, 32'h0000_00F0);
        run_instr(2, 1'b1, 1'b0, 1'b0, 1'b0, $urandom, 32'h0000_0203);
`ifndef PC_MISALIGN_TRAP_EN
        chk("jalr_pc", pc, 32'h0000_0202);
`endif
        finish_segment();

        // jump beats halt, then a real halt
        do_reset();
        run_instr(0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0040, $urandom);
        run_instr(0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0008, $urandom);
        chk("jump_over_halt_pc", pc, 32'h0000_0048);
        chk("jump_over_halt_halted", {31'd0, halted}, 32'd0);
        run_instr(0, 1'b0, 1'b0, 1'b0, 1'b1, $urandom, $urandom);
        check_halt();
        chk("halt_pc_48", pc, 32'h0000_0048);

        // fetch timeout boundary
        do_reset();
        run_instr(TMO, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        check_halt();
        do_reset();
        run_instr(TMO - 1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("tmo_minus1_err", {31'd0, timeout_err}, 32'd0);
        run_instr(TMO - 1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        finish_segment();

        // reset while fetching 0x80
        do_reset();
        run_instr(0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0080, $urandom);
        @(negedge clk);
        chk("midfetch_pc", pc, 32'h0000_0080);
        chk("midfetch_req", {31'd0, imem_req}, 32'd1);
        do_reset();
        run_instr(0, 1'b0, 1'b0, 1'b0, 1'b0, $urandom, $urandom);
        finish_segment();

        // wrap of pc+4
        do_reset();
        run_instr(0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, $urandom);
        run_instr(0, 1'b0, 1'b0, 1'b0, 1'b0, $urandom, $urandom);
        chk("wrap_pc", pc, 32'h0000_0000);
        finish_segment();

`ifdef PC_MISALIGN_TRAP_EN
        do_reset();
        run_instr(0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0002, $urandom);
        check_halt();
        chk("misalign_pc", pc, 32'h0000_0000);
`endif

        // randomized segments
        for (int seg = 0; seg < 12; seg++) begin
            do_reset();
            for (int n = 0; n < 30 && !m_halted; n++) begin
                r = $urandom_range(0, 99);
                if (r < 3)      d = TMO;
                else if (r < 6) d = TMO - 1;
                else            d = $urandom_range(0, 3);
                iv = $urandom;
                if ($urandom_range(0, 3) != 0) iv[1:0] = 2'b00;
                run_instr(d, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
                          iv, $urandom);
            end
            finish_segment();
        end

        @(negedge clk);
        chk("fetch_queue_left", exp_fetch.size(), 32'd0);
        chk("exec_queue_left", exp_exec.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
